// File: rtl/partsel_pkg.sv
// partsel_pkg: shared FSM encoding, field/index widths and
// the latched move-command bundle for partsel_sched.
package partsel_pkg;

  localparam int FW = 8;
  localparam int IW = 5;
  localparam int WW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [IW-1:0] src;
    logic [IW-1:0] dst;
    logic [WW-1:0] width;
    logic          id;
    logic          err;
  } cmd_t;

  function automatic logic [FW-1:0] fmask(
    input logic [WW-1:0] w
  );
    logic [FW-1:0] m;
    for (int i = 0; i < FW; i++) begin
      m[i] = (WW'(i) < w);
    end
    return m;
  endfunction

endpackage

// File: rtl/partsel_rr_arb.sv
// partsel_rr_arb: 2-way round-robin arbiter. Ports: clk_i, rst_ni,
// en_i (arbitrate this cycle), req_i, gnt_o (one-hot or zero).
module partsel_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // ptr_q holds the last-granted requester; it loses ties
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    if (en_i) begin
      unique case (1'b1)
        (req_i == 2'b11): gnt_o = ptr_q ? 2'b01 : 2'b10;
        (req_i == 2'b01): gnt_o = 2'b01;
        (req_i == 2'b10): gnt_o = 2'b10;
        default:          gnt_o = 2'b00;
      endcase
      if (|req_i) ptr_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b1;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/partsel_sched.sv
// partsel_sched: field store with word load and arbitrated bit-field
// moves (IDLE->RD->WR->RSP). Ports: load_*, req_*, done_o, err_o, data_o, busy_o.
module partsel_sched
  import partsel_pkg::*;
#(
  parameter int DW = 32,
  parameter int LW = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [DW-1:0]   load_data_i,
  output logic            load_ready_o,
  input  logic [1:0]      req_valid_i,
  output logic [1:0]      req_ready_o,
  input  logic [2*IW-1:0] req_src_i,
  input  logic [2*IW-1:0] req_dst_i,
  input  logic [2*LW-1:0] req_len_i,
  output logic [1:0]      done_o,
  output logic            err_o,
  output logic [DW-1:0]   data_o,
  output logic            busy_o
);

  state_e        state_q, state_d;
  logic [DW-1:0] store_q, store_d;
  logic [FW-1:0] tmp_q, tmp_d;
  cmd_t          cmd_q, cmd_d, cmd_new;
  logic [1:0]    gnt;
  logic          idle;
  logic [LW-1:0] len_sel;
  logic [5:0]    src_end, dst_end;
  logic [FW-1:0] mask;

  assign idle = (state_q == S_IDLE);

  partsel_rr_arb u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (idle && !load_i),
    .req_i  (req_valid_i),
    .gnt_o  (gnt)
  );

  always_comb begin
    cmd_new.id  = gnt[1];
    cmd_new.src = gnt[1] ? req_src_i[2*IW-1:IW]
                         : req_src_i[IW-1:0];
    cmd_new.dst = gnt[1] ? req_dst_i[2*IW-1:IW]
                         : req_dst_i[IW-1:0];
    len_sel     = gnt[1] ? req_len_i[2*LW-1:LW]
                         : req_len_i[LW-1:0];
    cmd_new.width = WW'(len_sel) + WW'(1);
    // field end computed 6 bits wide so 31+8 cannot wrap
    src_end = 6'(cmd_new.src) + 6'(cmd_new.width);
    dst_end = 6'(cmd_new.dst) + 6'(cmd_new.width);
    cmd_new.err = (7'(src_end) > 7'(DW)) ||
                  (7'(dst_end) > 7'(DW));
  end

  assign mask = fmask(cmd_q.width);

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    tmp_d   = tmp_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_i) begin
          store_d = load_data_i;
        end else if (|gnt) begin
          cmd_d   = cmd_new;
          state_d = S_RD;
        end
      end
      S_RD: begin
        // source captured before the write so overlaps are safe
        tmp_d   = FW'(store_q >> cmd_q.src) & mask;
        state_d = S_WR;
      end
      S_WR: begin
        if (!cmd_q.err) begin
          store_d = (store_q & ~(DW'(mask) << cmd_q.dst))
                  | (DW'(tmp_q & mask) << cmd_q.dst);
        end
        state_d = S_RSP;
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      store_q <= '0;
      tmp_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      tmp_q   <= tmp_d;
      cmd_q   <= cmd_d;
    end
  end

  assign load_ready_o = idle && load_i;
  assign req_ready_o  = gnt;
  assign done_o = (state_q == S_RSP)
                ? (cmd_q.id ? 2'b10 : 2'b01) : 2'b00;
  assign err_o  = (state_q == S_RSP) && cmd_q.err;
  assign data_o = store_q;
  assign busy_o = !idle;

endmodule

// File: tb/tb_partsel_sched.sv
// tb_partsel_sched: randomized and directed checks of partsel_sched
// against a bit-level field-move model.
module tb_partsel_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        load_i;
  logic [31:0] load_data_i;
  logic        load_ready_o;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [9:0]  req_src_i;
  logic [9:0]  req_dst_i;
  logic [5:0]  req_len_i;
  logic [1:0]  done_o;
  logic        err_o;
  logic [31:0] data_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mstore;
  bit          mlast;

  always #5 clk_i = ~clk_i;

  partsel_sched #(.DW(32), .LW(3)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       (load_i),
    .load_data_i  (load_data_i),
    .load_ready_o (load_ready_o),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_src_i    (req_src_i),
    .req_dst_i    (req_dst_i),
    .req_len_i    (req_len_i),
    .done_o       (done_o),
    .err_o        (err_o),
    .data_o       (data_o),
    .busy_o       (busy_o)
  );

  // field move computed one bit at a time from the rules
  function automatic bit model_move(input int src, input int dst,
                                    input int len);
    int w;
    bit [7:0] t;
    w = len + 1;
    if (src + w > 32 || dst + w > 32) return 1'b1;
    t = '0;
    for (int i = 0; i < w; i++) t[i] = mstore[src + i];
    for (int i = 0; i < w; i++) mstore[dst + i] = t[i];
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_ni      = 1'b0;
    load_i      = 1'b0;
    load_data_i = '0;
    req_valid_i = '0;
    req_src_i   = '0;
    req_dst_i   = '0;
    req_len_i   = '0;
    step();
    step();
    rst_ni = 1'b1;
    mstore = '0;
    mlast  = 1'b1;
  endtask

  task automatic do_load(input logic [31:0] d);
    load_i      = 1'b1;
    load_data_i = d;
    step();
    load_i = 1'b0;
    mstore = d;
  endtask

  task automatic set_req(input int r, input int src,
                         input int dst, input int len);
    req_src_i[r*5 +: 5] = 5'(src);
    req_dst_i[r*5 +: 5] = 5'(dst);
    req_len_i[r*3 +: 3] = 3'(len);
    req_valid_i[r]      = 1'b1;
  endtask

  task automatic run_move(input int r, input int src,
                          input int dst, input int len,
                          output bit granted, output int lat,
                          output logic [1:0] dv, output logic ev,
                          output logic [31:0] dat,
                          output logic [1:0] done_after,
                          output logic busy_after);
    granted = 0;
    lat = -1;
    dv = '0;
    ev = 1'b0;
    dat = '0;
    done_after = '0;
    busy_after = 1'b0;
    set_req(r, src, dst, len);
    #1;
    for (int i = 0; i < 8 && !granted; i++) begin
      if (req_ready_o[r]) granted = 1;
      else step();
    end
    if (granted) begin
      step();
      req_valid_i[r] = 1'b0;
      for (int k = 0; k < 6 && lat < 0; k++) begin
        if (done_o != 2'b00) begin
          lat = k;
          dv  = done_o;
          ev  = err_o;
          dat = data_o;
        end else begin
          step();
        end
      end
      step();
      done_after = done_o;
      busy_after = busy_o;
    end
    req_valid_i[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    load_i = 1'b0;
    req_valid_i = '0;
    step();
    checks++;
    if (data_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0", data_o);
    end
    checks++;
    if ({busy_o, done_o, err_o, req_ready_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0",
               {busy_o, done_o, err_o, req_ready_o});
    end
    apply_reset();
  endtask

  task automatic test_basic();
    bit g; int lat; logic [1:0] dv, da; logic ev, ba;
    logic [31:0] dat;
    load_i = 1'b1;
    load_data_i = 32'h0000_00A5;
    #1;
    checks++;
    if (load_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL load_ready_idle got=%b want=1", load_ready_o);
    end
    step();
    load_i = 1'b0;
    mstore = 32'h0000_00A5;
    run_move(0, 0, 24, 7, g, lat, dv, ev, dat, da, ba);
    checks++;
    if (!g || lat !== 2) begin
      failures++;
      $display("FAIL basic_latency got=%0d want=2 granted=%0d",
               lat, g);
    end
    checks++;
    if (dat !== 32'hA500_00A5) begin
      failures++;
      $display("FAIL basic_data got=%h want=a50000a5", dat);
    end
    checks++;
    if (dv !== 2'b01 || ev !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got=%b/%b want=01/0", dv, ev);
    end
    checks++;
    if (da !== 2'b00 || ba !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse got=%b/%b want=00/0", da, ba);
    end
  endtask

  task automatic test_rr();
    logic [1:0] exp;
    bit idle_seen;
    apply_reset();
    set_req(0, 0, 8, 0);
    set_req(1, 0, 8, 0);
    for (int n = 0; n < 3; n++) begin
      idle_seen = 0;
      for (int i = 0; i < 8 && !idle_seen; i++) begin
        if (!busy_o) idle_seen = 1;
        else step();
      end
      #1;
      exp = mlast ? 2'b01 : 2'b10;
      checks++;
      if (!idle_seen || req_ready_o !== exp) begin
        failures++;
        $display("FAIL rr_grant%0d got=%b want=%b", n,
                 req_ready_o, exp);
      end
      step();
      mlast = exp[1];
      checks++;
      if (req_ready_o !== 2'b00) begin
        failures++;
        $display("FAIL rr_busy_ready got=%b want=00", req_ready_o);
      end
    end
    req_valid_i = '0;
    step();
    step();
    step();
  endtask

  task automatic test_overlap();
    bit g; int lat; logic [1:0] dv, da; logic ev, ba;
    logic [31:0] dat;
    do_load(32'h0000_00FF);
    run_move(1, 0, 4, 7, g, lat, dv, ev, dat, da, ba);
    checks++;
    if (!g || dat !== 32'h0000_0FFF || dv !== 2'b10) begin
      failures++;
      $display("FAIL overlap got=%h/%b want=00000fff/10", dat, dv);
    end
  endtask

  task automatic test_range_err();
    bit g; int lat; logic [1:0] dv, da; logic ev, ba;
    logic [31:0] dat;
    do_load(32'h1357_2468);
    run_move(0, 28, 0, 7, g, lat, dv, ev, dat, da, ba);
    checks++;
    if (!g || ev !== 1'b1 || dv !== 2'b01 ||
        dat !== 32'h1357_2468) begin
      failures++;
      $display("FAIL src_err got=%b/%b/%h want=1/01/13572468",
               ev, dv, dat);
    end
    run_move(1, 0, 30, 3, g, lat, dv, ev, dat, da, ba);
    checks++;
    if (!g || ev !== 1'b1 || dv !== 2'b10 ||
        dat !== 32'h1357_2468) begin
      failures++;
      $display("FAIL dst_err got=%b/%b/%h want=1/10/13572468",
               ev, dv, dat);
    end
    run_move(1, 24, 24, 7, g, lat, dv, ev, dat, da, ba);
    checks++;
    if (!g || ev !== 1'b0 || dat !== 32'h1357_2468) begin
      failures++;
      $display("FAIL edge_ok got=%b/%h want=0/13572468", ev, dat);
    end
  endtask

  task automatic test_load_during_wr();
    bit g;
    do_load(32'h0000_00C3);
    set_req(0, 0, 16, 7);
    #1;
    g = 0;
    for (int i = 0; i < 8 && !g; i++) begin
      if (req_ready_o[0]) g = 1;
      else step();
    end
    step();
    req_valid_i = '0;
    step();
    load_i = 1'b1;
    load_data_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (!g || load_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL wr_load_ready got=%b want=0", load_ready_o);
    end
    step();
    load_i = 1'b0;
    checks++;
    if (done_o !== 2'b01 || data_o !== 32'h00C3_00C3) begin
      failures++;
      $display("FAIL wr_load_ignored got=%b/%h want=01/00c300c3",
               done_o, data_o);
    end
    step();
    load_i = 1'b1;
    #1;
    checks++;
    if (load_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL idle_load_ready got=%b want=1", load_ready_o);
    end
    step();
    load_i = 1'b0;
    mstore = 32'hDEAD_BEEF;
    checks++;
    if (data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL idle_load got=%h want=deadbeef", data_o);
    end
  endtask

  task automatic test_reset_mid();
    bit g;
    int seen;
    do_load(32'h0F0F_0F0F);
    set_req(0, 0, 8, 3);
    #1;
    g = 0;
    for (int i = 0; i < 8 && !g; i++) begin
      if (req_ready_o[0]) g = 1;
      else step();
    end
    step();
    req_valid_i = '0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (!g || data_o !== 32'h0 || busy_o !== 1'b0 ||
        done_o !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset got=%h/%b/%b want=0/0/00",
               data_o, busy_o, done_o);
    end
    step();
    rst_ni = 1'b1;
    mstore = '0;
    mlast = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done_o !== 2'b00 || data_o !== 32'h0) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid_reset_after got=%0d events want=0", seen);
    end
  endtask

  task automatic test_random();
    bit g; int lat; logic [1:0] dv, da; logic ev, ba;
    logic [31:0] dat;
    int r, s, d, l;
    bit merr;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3) == 0) begin
        do_load($urandom);
        checks++;
        if (data_o !== mstore) begin
          failures++;
          $display("FAIL rnd_load%0d got=%h want=%h", n,
                   data_o, mstore);
        end
      end else begin
        r = int'($urandom_range(1));
        s = int'($urandom_range(31));
        d = int'($urandom_range(31));
        l = int'($urandom_range(7));
        merr = model_move(s, d, l);
        run_move(r, s, d, l, g, lat, dv, ev, dat, da, ba);
        checks++;
        if (!g || lat !== 2 || dv !== (r == 1 ? 2'b10 : 2'b01) ||
            ev !== merr || dat !== mstore || da !== 2'b00) begin
          failures++;
          $display("FAIL rnd_move%0d got=%0d/%b/%b/%h want=2/r%0d/%b/%h",
                   n, lat, dv, ev, dat, r, merr, mstore);
        end
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    load_i = 1'b0;
    load_data_i = '0;
    req_valid_i = '0;
    req_src_i = '0;
    req_dst_i = '0;
    req_len_i = '0;
    mstore = '0;
    mlast = 1'b1;
    test_reset();
    test_basic();
    test_rr();
    test_overlap();
    test_range_err();
    test_load_during_wr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/partsel_sched.md
PARTSEL_SCHED -- requirements
Module: partsel_sched

Interface
REQ-001 SHALL have parameter DW, default 32, meaning field-store word width in bits.
REQ-002 SHALL have parameter LW, default 3, meaning the length-code width, so field width = len+1 in the range 1..8.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port load_i, input, 1 bit: whole-word load strobe.
REQ-006 SHALL have port load_data_i, input, DW bits: the word to load.
REQ-007 SHALL have port load_ready_o, output, 1 bit: high when a load is accepted this cycle.
REQ-008 SHALL have port req_valid_i, input, 2 bits: move-command valid, one bit per requester.
REQ-009 SHALL have port req_ready_o, output, 2 bits: move-command accept, one bit per requester.
REQ-010 SHALL have port req_src_i, input, 2x5 bits (packed): source field LSB index per requester.
REQ-011 SHALL have port req_dst_i, input, 2x5 bits (packed): destination field LSB index per requester.
REQ-012 SHALL have port req_len_i, input, 2xLW bits (packed): length code per requester.
REQ-013 SHALL have port done_o, output, 2 bits: one-cycle completion pulse per requester.
REQ-014 SHALL have port err_o, output, 1 bit: range-error flag, valid only while a done_o bit is high.
REQ-015 SHALL have port data_o, output, DW bits: current field-store contents.
REQ-016 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> RD -> WR -> RSP -> IDLE, advancing one state per clock.
REQ-018 SHALL, in IDLE, give load_i priority: load_ready_o=1 and store<=load_data_i at the edge; no move is granted that cycle.
REQ-019 SHALL hold load_ready_o=0 outside IDLE; a load_i presented then is ignored (not queued).
REQ-020 SHALL, in IDLE with no load_i, arbitrate round-robin among valid requesters; exactly one req_ready_o bit is high; the handshake completes on valid&&ready.
REQ-021 SHALL update the round-robin pointer only on a grant; the last-granted requester loses a tie.
REQ-022 SHALL latch src, dst and width (len+1) of the granted requester, plus its id, on acceptance.
REQ-023 SHALL, in RD, copy store[src +: width] into an 8-bit temporary, zero-extended above width.
REQ-024 SHALL, in WR, write temporary[width-1:0] to store[dst +: width] and leave all other bits unchanged.
REQ-025 SHALL handle overlapping src/dst fields correctly, because the source is captured in RD before the WR write.
REQ-026 SHALL flag a range error when src+width>DW or dst+width>DW, computed 6 bits wide; on error WR performs no write.
REQ-027 SHALL, in RSP, pulse done_o[id]=1 for exactly one cycle with err_o set as computed; both are 0 otherwise.
REQ-028 SHALL have fixed latency: acceptance at edge N, data_o updated at edge N+2, done_o high during cycle N+3.
REQ-029 SHALL hold all req_ready_o bits at 0 while busy; requesters keep valid asserted until accepted.

Reset
REQ-030 SHALL, while rst_ni=0, force state=IDLE, store=0, temporary=0, round-robin pointer=requester 1 (so requester 0 wins the first tie), done_o=0, err_o=0.
REQ-031 SHALL abandon an in-flight move when reset asserts mid-operation: no partial write and no done_o pulse after release.

Structure
REQ-032 SHALL place FSM state encoding, the field-width constant 8 and the index width 5 in a shared package partsel_pkg.
REQ-033 SHALL use one sub-module, partsel_rr_arb: a 2-way round-robin arbiter with grant and pointer update.

Verification
REQ-034 SHALL verify: load 0x000000A5, req0 src=0 dst=24 len=7 -> data_o=0xA50000A5, done_o=01, err_o=0, done in cycle N+3.
REQ-035 SHALL verify: both requesters valid from reset -> req0 granted first, then req1, then req0 (alternating).
REQ-036 SHALL verify: load 0x000000FF, src=0 dst=4 len=7 (overlap) -> data_o=0x00000FFF.
REQ-037 SHALL verify: src=28 len=7 -> err_o=1 with done_o, data_o unchanged.
REQ-038 SHALL verify: load_i asserted during WR -> load ignored, move result intact; load then accepted in the next IDLE.
REQ-039 SHALL verify: rst_ni low during RD -> data_o=0, busy_o=0, and no done_o pulse after release.
